// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start, 8 data bits LSB-first, even parity, stop.
// Bit timing comes from the baud generator's oversampled sample_ENABLE ticks.
module uart_tx_sequencer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select_in,
  input  logic       sample_ENABLE,
  output logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  function automatic logic f_even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  logic [2:0] r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_txd;
  logic       r_busy;
  logic       r_done;
  logic [2:0] r_baud;

  logic       w_accept;
  logic       w_bit_end;
  logic [2:0] w_state_nxt;
  logic [3:0] w_tick_nxt;
  logic [2:0] w_bit_idx_nxt;
  logic [7:0] w_shift_nxt;
  logic       w_parity_nxt;
  logic       w_txd_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic [2:0] w_baud_nxt;

  assign w_accept  = (r_state == S_IDLE) && !r_busy && Tx_WR && Tx_EN;
  assign w_bit_end = sample_ENABLE && (r_tick_cnt == TICK_LAST);

  // Oversample tick counter; idle keeps it at zero so the accept-cycle tick is never counted.
  always_comb begin
    w_tick_nxt = r_tick_cnt;
    if (r_state == S_IDLE) begin
      w_tick_nxt = 4'd0;
    end else if (w_bit_end) begin
      w_tick_nxt = 4'd0;
    end else if (sample_ENABLE) begin
      w_tick_nxt = r_tick_cnt + 4'd1;
    end else begin
      w_tick_nxt = r_tick_cnt;
    end
  end

  // Frame state machine; TxD is computed for the next bit so the line register never glitches.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_txd_nxt     = r_txd;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_baud_nxt    = r_baud;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = baud_select_in;
        if (w_accept) begin
          w_shift_nxt   = Tx_DATA;
          w_parity_nxt  = f_even_parity(Tx_DATA);
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_START;
        end else begin
          w_txd_nxt     = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = r_shift[0];
          w_state_nxt   = S_DATA;
        end else begin
          w_state_nxt   = S_START;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = 3'd0;
            w_txd_nxt     = r_parity;
            w_state_nxt   = S_PARITY;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = r_shift[1];
            w_state_nxt   = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_txd_nxt   = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_txd_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_baud     <= 3'b000;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_baud     <= w_baud_nxt;
    end
  end

  assign baud_select = r_baud;
  assign TxD         = r_txd;
  assign Tx_BUSY     = r_busy;
  assign Tx_DONE     = r_done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed self-checking bench for uart_tx_sequencer with a behavioural tick generator.
module tb_uart_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select_in;
  logic       sample_ENABLE = 1'b0;
  logic [2:0] baud_select;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  int compared   = 0;
  int mismatched = 0;
  int div        = 54;
  int gen_cnt    = 0;
  int tick_seen  = 0;
  int cyc        = 0;
  int t16        = 0;
  int early_done = 0;
  int busy_drop  = 0;
  bit in_frame   = 1'b0;
  bit timed_out  = 1'b0;

  localparam logic [10:0] FRAME_A5 = 11'b10101001010;
  localparam logic [10:0] FRAME_07 = 11'b11000001110;
  localparam logic [10:0] FRAME_00 = 11'b10000000000;
  localparam logic [10:0] FRAME_55 = 11'b10010101010;

  uart_tx_sequencer #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .Tx_EN          (Tx_EN),
    .Tx_WR          (Tx_WR),
    .Tx_DATA        (Tx_DATA),
    .baud_select_in (baud_select_in),
    .sample_ENABLE  (sample_ENABLE),
    .baud_select    (baud_select),
    .TxD            (TxD),
    .Tx_BUSY        (Tx_BUSY),
    .Tx_DONE        (Tx_DONE)
  );

  always #5 clk = ~clk;

  // Baud generator model: one-cycle tick every div clocks, updated away from the active edge.
  always @(negedge clk) begin
    gen_cnt = (gen_cnt >= div - 1) ? 0 : gen_cnt + 1;
    sample_ENABLE = (gen_cnt == div - 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sample_ENABLE === 1'b1) begin
      tick_seen++;
      if (tick_seen == 16) t16 = cyc;
    end
    if (in_frame && tick_seen < 176) begin
      if (Tx_DONE !== 1'b0) early_done++;
      if (Tx_BUSY !== 1'b1) busy_drop++;
    end
  endtask

  task automatic wait_ticks(input string tag, input int target);
    int guard = 0;
    int limit;
    limit = (target - tick_seen + 2) * div + 20;
    while (tick_seen < target && guard < limit) begin
      step();
      guard++;
    end
    if (tick_seen < target) begin
      timed_out = 1'b1;
      chk({tag, "_timeout"}, tick_seen, target);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    step();
    Tx_WR   = 1'b0;
    tick_seen = 0;
  endtask

  task automatic write_on_tick(input logic [7:0] d);
    int guard = 0;
    while (gen_cnt != div - 2 && guard < 4 * div) begin
      step();
      guard++;
    end
    do_write(d);
  endtask

  task automatic watch_idle(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      step();
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Called right after the accepting edge; returns in the Tx_DONE cycle.
  task automatic run_frame(input string tag, input logic [10:0] exp,
                           input bit busy_wr, input bit baud_chg);
    int t176;
    tick_seen  = 0;
    early_done = 0;
    busy_drop  = 0;
    timed_out  = 1'b0;
    in_frame   = 1'b1;
    chk({tag, "_busy_at_accept"}, Tx_BUSY, 1);
    chk({tag, "_txd_at_accept"}, TxD, 0);
    for (int k = 0; k < 11; k++) begin
      wait_ticks(tag, 16 * k + 8);
      if (timed_out) begin
        in_frame = 1'b0;
        return;
      end
      chk($sformatf("%s_bit%0d", tag, k), TxD, exp[k]);
      if (k == 4 && busy_wr) begin
        Tx_DATA = 8'h3C;
        Tx_WR   = 1'b1;
        step();
        Tx_WR   = 1'b0;
      end
      if (k == 4 && baud_chg) baud_select_in = 3'b110;
      if (k == 10 && baud_chg) chk({tag, "_baud_held_mid"}, baud_select, 3'b111);
    end
    wait_ticks(tag, 176);
    in_frame = 1'b0;
    if (timed_out) return;
    t176 = cyc;
    chk({tag, "_done_pulse"}, Tx_DONE, 1);
    chk({tag, "_busy_clear"}, Tx_BUSY, 0);
    chk({tag, "_txd_idle"}, TxD, 1);
    chk({tag, "_no_early_done"}, early_done, 0);
    chk({tag, "_busy_held"}, busy_drop, 0);
    chk({tag, "_ten_bit_clocks"}, t176 - t16, 160 * div);
    chk({tag, "_baud_at_done"}, baud_select, 3'b111);
  endtask

  initial begin
    reset          = 1'b1;
    Tx_EN          = 1'b0;
    Tx_WR          = 1'b0;
    Tx_DATA        = 8'h00;
    baud_select_in = 3'b111;
    div            = 54;

    step();
    chk("rst_txd", TxD, 1);
    chk("rst_busy", Tx_BUSY, 0);
    chk("rst_done", Tx_DONE, 0);
    chk("rst_baud", baud_select, 3'b000);
    step();
    reset = 1'b0;
    step();
    chk("idle_baud_follow", baud_select, 3'b111);
    Tx_EN = 1'b1;

    // Basic frame at 54 clocks per tick: 864 clocks per bit.
    do_write(8'hA5);
    run_frame("basic", FRAME_A5, 1'b0, 1'b0);
    step();
    chk("basic_done_single", Tx_DONE, 0);
    chk("basic_busy_low", Tx_BUSY, 0);

    div = 3;
    watch_idle("settle", 6);

    // Parity frames; the 07 write lands on a tick edge, which must not count toward START.
    write_on_tick(8'h07);
    run_frame("par07", FRAME_07, 1'b0, 1'b0);
    step();
    do_write(8'h00);
    run_frame("par00", FRAME_00, 1'b0, 1'b0);
    step();

    do_write(8'hA5);
    run_frame("busy", FRAME_A5, 1'b1, 1'b0);
    watch_idle("busy_no_follow", 60);

    Tx_EN = 1'b0;
    do_write(8'hFF);
    chk("en_off_busy", Tx_BUSY, 0);
    chk("en_off_txd", TxD, 1);
    watch_idle("en_no_follow", 60);
    Tx_EN = 1'b1;

    do_write(8'hA5);
    run_frame("baud", FRAME_A5, 1'b0, 1'b1);
    step();
    chk("baud_after_done", baud_select, 3'b110);
    baud_select_in = 3'b111;
    step();

    // Back-to-back: second write issued during the Tx_DONE cycle.
    do_write(8'hA5);
    run_frame("b2b_a", FRAME_A5, 1'b0, 1'b0);
    do_write(8'h55);
    run_frame("b2b_b", FRAME_55, 1'b0, 1'b0);
    step();
    chk("b2b_done_single", Tx_DONE, 0);

    // Reset held two cycles in the middle of DATA.
    do_write(8'hA5);
    wait_ticks("rst_mid", 16 * 3 + 8);
    chk("rst_mid_pre_bit", TxD, FRAME_A5[3]);
    reset = 1'b1;
    step();
    chk("rst_mid_txd", TxD, 1);
    chk("rst_mid_busy", Tx_BUSY, 0);
    chk("rst_mid_done", Tx_DONE, 0);
    chk("rst_mid_baud", baud_select, 3'b000);
    step();
    chk("rst_mid2_txd", TxD, 1);
    chk("rst_mid2_busy", Tx_BUSY, 0);
    reset = 1'b0;
    watch_idle("rst_quiet", 100);

    // Reset wins over a simultaneous write.
    reset   = 1'b1;
    Tx_DATA = 8'h81;
    Tx_WR   = 1'b1;
    step();
    reset = 1'b0;
    Tx_WR = 1'b0;
    chk("rst_wr_busy", Tx_BUSY, 0);
    chk("rst_wr_txd", TxD, 1);
    watch_idle("rst_wr_quiet", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
